// File: rtl/frame_clear_engine.sv
// frame_clear_engine
// Raster-sweep generator for the renderer's Clear phase. While clear_start is
// held it walks every framebuffer pixel in row-major order, presenting one
// write (coordinates + CLEAR_COLOR + write-enable) per accepted cycle, then
// raises clear_done until clear_start is released.
//
// Ports:
//   Clk          in   1   system clock, rising edge
//   Reset        in   1   synchronous, active-high
//   clear_start  in   1   level request from the sequencer, held for the phase
//   mem_ready    in   1   downstream accepts the presented write this cycle
//   clear_DrawX  out  10  column of the presented write
//   clear_DrawY  out  10  row of the presented write
//   clear_we     out  1   a write is being presented
//   clear_color  out  24  write data, always CLEAR_COLOR
//   clear_done   out  1   sweep complete (level)
//
// state  | meaning
// IDLE   | no write presented, counters at 0, waiting for clear_start
// SWEEP  | presenting writes, advancing on each accept
// FINISH | whole frame written, clear_done held until clear_start drops

module frame_clear_engine #(
  parameter int          H_PIXELS    = 640,
  parameter int          V_PIXELS    = 480,
  parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear_start,
  input  logic        mem_ready,
  output logic [9:0]  clear_DrawX,
  output logic [9:0]  clear_DrawY,
  output logic        clear_we,
  output logic [23:0] clear_color,
  output logic        clear_done
);

  localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0] Y_LAST = 10'(V_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_FINISH
  } state_t;

  state_t     state_q;
  logic [9:0] x_cnt_q;
  logic [9:0] y_cnt_q;
  logic       we_q;
  logic       done_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          x_cnt_q <= '0;
          y_cnt_q <= '0;
          if (clear_start) begin
            state_q <= ST_SWEEP;
          end
        end

        ST_SWEEP: begin
          if (!clear_start) begin
            // Abort: a partial frame is never reported as done.
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
          end else if (!we_q) begin
            // First Sweep cycle raises the write-enable for pixel (0,0).
            we_q <= 1'b1;
          end else if (mem_ready) begin
            if (x_cnt_q != X_LAST) begin
              x_cnt_q <= x_cnt_q + 10'd1;
            end else if (y_cnt_q != Y_LAST) begin
              x_cnt_q <= '0;
              y_cnt_q <= y_cnt_q + 10'd1;
            end else begin
              // Last pixel accepted; coordinates stay parked on it.
              state_q <= ST_FINISH;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        ST_FINISH: begin
          we_q <= 1'b0;
          if (clear_start) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          x_cnt_q <= '0;
          y_cnt_q <= '0;
        end
      endcase
    end
  end

  assign clear_DrawX = x_cnt_q;
  assign clear_DrawY = y_cnt_q;
  assign clear_we    = we_q;
  assign clear_done  = done_q;
  assign clear_color = CLEAR_COLOR;

endmodule
